gprs_mp: RTL



---
 rtl/gprs_mp_if.sv | 44 ++++
 rtl/gprs_mp.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/gprs_mp_if.sv
// gprs_mp bus: WB write, DEC read/scoreboard and debug access.
// master = core/debug side, slave = register file.
interface gprs_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic                         wr_valid;
  logic [IDX_W-1:0]             rd_wb;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic [NUM_RD*IDX_W-1:0]      rs_idx;
  logic [NUM_RD*DATA_WIDTH-1:0] rs_data;
  logic [NUM_RD-1:0]            rs_busy;
  logic                         sb_set;
  logic [IDX_W-1:0]             sb_set_idx;
  logic                         sb_flush;
  logic                         dbg_req;
  logic                         dbg_wr1_rd0;
  logic [15:0]                  dbg_regno;
  logic [DATA_WIDTH-1:0]        dbg_write_data;
  logic                         dbg_ack;
  logic                         dbg_err;
  logic [DATA_WIDTH-1:0]        dbg_read_data;

  modport master (
    output wr_valid, rd_wb, wr_data, rs_idx,
    output sb_set, sb_set_idx, sb_flush,
    output dbg_req, dbg_wr1_rd0, dbg_regno,
    output dbg_write_data,
    input  rs_data, rs_busy,
    input  dbg_ack, dbg_err, dbg_read_data
  );

  modport slave (
    input  wr_valid, rd_wb, wr_data, rs_idx,
    input  sb_set, sb_set_idx, sb_flush,
    input  dbg_req, dbg_wr1_rd0, dbg_regno,
    input  dbg_write_data,
    output rs_data, rs_busy,
    output dbg_ack, dbg_err, dbg_read_data
  );
endinterface

// File: rtl/gprs_mp.sv
// gprs_mp: parametrised GPR file with WB bypass,
// pending-producer scoreboard and debug access port.
module gprs_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter bit ZERO_REG   = 1'b1
) (
  input logic      cpu_clk,
  input logic      cpu_rst,
  gprs_mp_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [15:0] BASE = 16'h1000;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {
    IDLE, WAIT, ACK
  } state_t;

  word_t               regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  state_t              state;

  idx_t  dbg_idx;
  logic  dbg_hit;
  logic  dbg_go;
  logic  dbg_we;
  logic  dbg_byp;
  word_t dbg_rd;

  function automatic logic is_zero(idx_t i);
    return ZERO_REG && (i == '0);
  endfunction

  // Read ports: storage with same-cycle WB bypass.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    idx_t i;
    logic wb_hit;
    assign i = bus.rs_idx[k*IDX_W +: IDX_W];
    assign wb_hit = bus.wr_valid &&
                    (bus.rd_wb == i);
    assign bus.rs_data[k*DATA_WIDTH +: DATA_WIDTH] =
      (wb_hit && !is_zero(i)) ?
      bus.wr_data : regs[i];
    assign bus.rs_busy[k] = pend[i] && !wb_hit;
  end

  assign dbg_idx = bus.dbg_regno[IDX_W-1:0];
  assign dbg_hit = bus.dbg_regno[15:IDX_W] ==
                   BASE[15:IDX_W];
  assign dbg_byp = bus.wr_valid &&
                   (bus.rd_wb == dbg_idx) &&
                   !is_zero(dbg_idx);
  assign dbg_rd  = dbg_byp ? bus.wr_data
                           : regs[dbg_idx];

  // Debug write commits only in a cycle free of WB.
  assign dbg_go =
    !bus.wr_valid &&
    ((state == IDLE && bus.dbg_req && dbg_hit &&
      bus.dbg_wr1_rd0) ||
     (state == WAIT));
  assign dbg_we = dbg_go && !is_zero(dbg_idx);

  // Register storage: WB port plus debug write port.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
    end else begin
      if (bus.wr_valid && !is_zero(bus.rd_wb))
        regs[bus.rd_wb] <= bus.wr_data;
      if (dbg_we)
        regs[dbg_idx] <= bus.dbg_write_data;
    end
  end

  // Scoreboard: flush > set > WB clear.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      pend <= '0;
    end else if (bus.sb_flush) begin
      pend <= '0;
    end else begin
      if (bus.wr_valid)
        pend[bus.rd_wb] <= 1'b0;
      if (bus.sb_set && !is_zero(bus.sb_set_idx))
        pend[bus.sb_set_idx] <= 1'b1;
    end
  end

  // Debug handshake FSM with registered ack/err/data.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state             <= IDLE;
      bus.dbg_ack       <= 1'b0;
      bus.dbg_err       <= 1'b0;
      bus.dbg_read_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.dbg_req) begin
            if (!dbg_hit) begin
              state       <= ACK;
              bus.dbg_ack <= 1'b1;
              bus.dbg_err <= 1'b1;
            end else if (bus.dbg_wr1_rd0 &&
                         bus.wr_valid) begin
              state <= WAIT;
            end else begin
              state       <= ACK;
              bus.dbg_ack <= 1'b1;
              bus.dbg_err <= 1'b0;
              if (!bus.dbg_wr1_rd0)
                bus.dbg_read_data <= dbg_rd;
            end
          end
        end
        WAIT: begin
          if (!bus.wr_valid) begin
            state       <= ACK;
            bus.dbg_ack <= 1'b1;
            bus.dbg_err <= 1'b0;
          end
        end
        ACK: begin
          if (!bus.dbg_req) begin
            state       <= IDLE;
            bus.dbg_ack <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          bus.dbg_ack <= 1'b0;
        end
      endcase
    end
  end
endmodule
